// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// - state_t : controller states (IDLE, CALC, DONE)
// - abs_val : two's-complement magnitude / conditional negate on a 64-bit
//             carrier. Callers zero- or sign-extend their operand into it and
//             truncate the result back to the width they need.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the carrier used by abs_val; operands must be narrower.
    localparam int ABS_W = 64;

    // Negate value when sign is set, otherwise pass it through unchanged.
    // Negation modulo 2^k only depends on the low k bits of the carrier.
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] value,
                                                 input logic             sign);
        logic [ABS_W-1:0] res;
        if (sign) begin
            res = ~value + 64'd1;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_seq_param_step.sv
// One iteration of restoring division: shift in the next dividend bit,
// compare with the divisor magnitude and subtract when it fits.
// Ports:
//   pr      : current partial remainder (always below |divisor|, so VW bits)
//   din     : next dividend bit, MSB first
//   dvs     : divisor magnitude, VW+1 bits (holds 2^VW for the most-negative divisor)
//   pr_next : updated partial remainder
//   qbit    : quotient bit produced by this step
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] pr,
    input  logic          din,
    input  logic [VW:0]   dvs,
    output logic [VW-1:0] pr_next,
    output logic          qbit
);

    logic [VW:0] shifted_s;
    logic [VW:0] diff_s;

    // Shift/compare/subtract for one quotient bit.
    always_comb begin
        shifted_s = {pr, din};
        diff_s    = shifted_s - dvs;
        if (shifted_s >= dvs) begin
            qbit    = 1'b1;
            // The difference is below |divisor| <= 2^VW, so it fits VW bits.
            pr_next = diff_s[VW-1:0];
        end else begin
            qbit    = 1'b0;
            pr_next = shifted_s[VW-1:0];
        end
    end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// signed (truncating) mode, divide-by-zero detection and valid/ready on both
// sides. All outputs are registered.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (accept in IDLE only)
//   dividend, divisor     : operands (DW / VW bits)
//   signed_mode           : two's-complement operation when SIGNED_EN != 0
//   out_valid/out_ready   : result handshake (result held in DONE)
//   quotient, remainder   : result (DW / VW bits)
//   div_by_zero           : result came from a zero divisor
module div_seq_param
    import div_pkg::*;
#(
    parameter int DW        = 16,
    parameter int VW        = 8,
    parameter int SIGNED_EN = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic          signed_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

    state_t          state_r;
    state_t          state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]   dmag_r;      // dividend magnitude, shifts left as quotient bits enter
    logic [VW:0]     dvs_mag_r;
    logic [VW-1:0]   pr_r;
    logic            dvd_neg_r;
    logic            dvs_neg_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [DW-1:0]   quotient_r;
    logic [VW-1:0]   remainder_r;
    logic            dbz_r;

    logic            sgn_s;
    logic            dvd_neg_s;
    logic            dvs_neg_s;
    logic            dvs_zero_s;
    logic [DW-1:0]   dvd_abs_s;
    logic [VW:0]     dvs_abs_s;
    logic [VW-1:0]   pr_next_s;
    logic            qbit_s;
    logic [DW-1:0]   q_mag_s;
    logic [DW-1:0]   q_fix_s;
    logic [VW-1:0]   r_fix_s;

    div_step #(.VW(VW)) u_step (
        .pr      (pr_r),
        .din     (dmag_r[DW-1]),
        .dvs     (dvs_mag_r),
        .pr_next (pr_next_s),
        .qbit    (qbit_s)
    );

    // Operand magnitudes on accept and sign fix-up of the final step.
    always_comb begin
        sgn_s      = (SIGNED_EN != 0) && signed_mode;
        dvd_neg_s  = sgn_s && dividend[DW-1];
        dvs_neg_s  = sgn_s && divisor[VW-1];
        dvs_zero_s = (divisor == {VW{1'b0}});
        // Dividend negation only needs its own DW bits; the most-negative
        // value maps to 2^(DW-1), still representable unsigned.
        dvd_abs_s  = DW'(abs_val(64'(dividend), dvd_neg_s));
        // Divisor magnitude needs VW+1 bits, so sign-extend before negating.
        dvs_abs_s  = (VW+1)'(abs_val({{(ABS_W-VW){dvs_neg_s}}, divisor}, dvs_neg_s));
        q_mag_s    = {dmag_r[DW-2:0], qbit_s};
        // Overflow (most-negative / -1) wraps naturally to the most-negative value.
        q_fix_s    = DW'(abs_val(64'(q_mag_s), dvd_neg_r ^ dvs_neg_r));
        r_fix_s    = VW'(abs_val(64'(pr_next_s), dvd_neg_r));
    end

    // Controller next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = dvs_zero_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Datapath: operand capture, bit iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            dmag_r      <= {DW{1'b0}};
            dvs_mag_r   <= {(VW+1){1'b0}};
            pr_r        <= {VW{1'b0}};
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cnt_r     <= CNT_W'(DW-1);
                        dmag_r    <= dvd_abs_s;
                        dvs_mag_r <= dvs_abs_s;
                        pr_r      <= {VW{1'b0}};
                        dvd_neg_r <= dvd_neg_s;
                        dvs_neg_r <= dvs_neg_s;
                        if (dvs_zero_s) begin
                            quotient_r  <= {DW{1'b1}};
                            remainder_r <= dividend[VW-1:0];
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dmag_r <= q_mag_s;
                    pr_r   <= pr_next_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        quotient_r  <= q_fix_s;
                        remainder_r <= r_fix_s;
                        dbz_r       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
- Parametrised multi-cycle restoring divider.
- Successor to the single-cycle combinational 16/8 divider: generic dividend/divisor widths, optional signed mode, divide-by-zero detection, and a valid/ready handshake on both sides.
- Sits on the datapath as a shared arithmetic unit. Produces one quotient bit per clock, so area stays small at any width.

Parameters:
- DW, 16, dividend and quotient width (>=2)
- VW, 8, divisor and remainder width (2..DW)
- SIGNED_EN, 0, 1 = signed_mode input is honoured; 0 = signed_mode is ignored and all operations are unsigned

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  DW  dividend
- divisor  input  VW  divisor
- signed_mode  input  1  two's-complement operation; sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DW  quotient
- remainder  output  VW  remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state returns to IDLE from any state, including mid-CALC;
  - the in-flight operation is discarded;
  - in_ready=0 during reset; out_valid=0; quotient=0; remainder=0; div_by_zero=0; internal registers cleared.
- State IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch operands and sgn = SIGNED_EN && signed_mode.
  - If divisor==0, go to DONE; otherwise go to CALC with bit counter = DW-1.
- Magnitudes (taken on accept when sgn=1):
  - |dividend| and |divisor| are taken in DW and VW+1 bits.
  - The most-negative dividend yields 2^(DW-1), which is representable in the unsigned working register.
- State CALC (one cycle per bit, MSB first):
  - Partial remainder pr (VW+1 bits): pr' = {pr, next dividend bit}.
  - If pr' >= |divisor|: subtract and set the quotient bit to 1; otherwise set it to 0.
  - After DW cycles (counter reaches 0), apply signs and go to DONE. in_ready=0.
- Sign fix-up (truncating division, C semantics):
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend;
  - the result satisfies dividend = q*divisor + r with |r| < |divisor|.
  - Overflow case (most negative / -1): quotient wraps to the most-negative value, remainder=0. No flag is raised.
- Divide by zero (skips CALC):
  - quotient = all ones;
  - remainder = dividend[VW-1:0] (raw bits, no sign fix);
  - div_by_zero=1.
- State DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable and registered.
  - On out_ready, go to IDLE; out_valid falls on the next edge.
  - Result persists for any number of cycles without out_ready.
- Latency, counted from the accepting edge:
  - out_valid is high after DW+1 edges for normal operands;
  - out_valid is high after 1 edge for a zero divisor.
  - Throughput is one operation per DW+2 cycles at most; no overlap is allowed. in_ready=0 in CALC and DONE.
- Output persistence: outputs hold their last result in IDLE until the next result is written. out_valid alone qualifies them.
- Simultaneous events:
  - in_valid arriving while in CALC/DONE is ignored; the upstream side holds it.
  - Reset wins over every handshake.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, CALC, DONE);
  - helper function abs_val(value, sign) for magnitude and negate;
  - localparam CNT_W = $clog2(DW).
- One natural sub-module, div_step: the combinational shift/compare/subtract for one bit. Inputs pr, next dividend bit, divisor magnitude; outputs new pr and quotient bit. Instantiated once.
- Everything else stays in div_seq_param: FSM, counter, sign handling, output registers.

Test Plan:
- Unsigned 1000/7 (DW=16, VW=8), out_ready=1 -> quotient=142, remainder=6, div_by_zero=0, out_valid exactly 17 edges after accept, then in_ready=1 again.
- Divide by zero 1234/0 -> one edge later out_valid=1, quotient=0xFFFF, remainder=0xD2, div_by_zero=1.
- Signed (SIGNED_EN=1, signed_mode=1) -100/7 -> quotient=0xFFF2 (-14), remainder=0xFE (-2). Then 100/-7 -> quotient=0xFFF2, remainder=0x02.
- Signed overflow -32768/-1 -> quotient=0x8000, remainder=0, div_by_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0, new in_valid ignored. Release -> IDLE next edge, and the queued operand is accepted.
- Reset mid-operation: rst_n=0 during cycle 5 of CALC -> next edge all outputs 0, state IDLE. After release, 255/16 completes with quotient=15, remainder=15.
